int_arbiter: RTL and testbench

INT_ARBITER -- requirements
Module: int_arbiter

---
 rtl/int_arbiter.sv | 120 ++++++++++++
 tb/tb_int_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_arbiter.sv
// Fixed-priority interrupt arbiter: per-source rising-edge capture into pending
// bits, an enable mask, and an IDLE/ASSERT/SERVICE handshake with the CPU.

module int_arbiter_src (
  input  logic clk,
  input  logic rst,
  input  logic armed,
  input  logic req,
  input  logic clr,
  output logic pending
);
  logic prev;

  // A new edge in the same cycle as a clear leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev    <= req;
      pending <= (pending & ~clr) | (armed & req & ~prev);
    end
  end
endmodule

module int_arbiter #(
  parameter int NSRC = 8,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] req,
  input  logic            mask_wr,
  input  logic [NSRC-1:0] mask_data,
  input  logic            ack,
  input  logic            eoi,
  output logic            int_out,
  output logic [IDW-1:0]  src_id,
  output logic [NSRC-1:0] pending,
  output logic            busy
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [NSRC-1:0] enable, enable_nxt, clr, eligible;
  logic [IDW-1:0]  sel_id;
  logic            sel_vld;
  logic            armed;
  logic            cool;

  // armed suppresses edge detection on the first clock after reset, so a
  // level held high through reset is not mistaken for a new request.
  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_src
      int_arbiter_src u_src (
        .clk     (clk),
        .rst     (rst),
        .armed   (armed),
        .req     (req[g]),
        .clr     (clr[g]),
        .pending (pending[g])
      );
    end
  endgenerate

  assign enable_nxt = mask_wr ? mask_data : enable;
  assign eligible   = pending & enable;
  assign busy       = (state != S_IDLE);

  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_vld = 1'b1;
        sel_id  = IDW'(i);
      end
    end
  end

  // cool holds IDLE one extra cycle after eoi so int_out is low >= 2 cycles.
  always_comb begin
    state_nxt = state;
    clr       = '0;
    case (state)
      S_IDLE:    if (!cool && sel_vld) state_nxt = S_ASSERT;
      S_ASSERT: begin
        if (ack) begin
          state_nxt   = S_SERVICE;
          clr[src_id] = 1'b1;
        end else if (!enable_nxt[src_id]) begin
          state_nxt = S_IDLE;
        end
      end
      S_SERVICE: if (eoi) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      enable  <= '0;
      src_id  <= '0;
      int_out <= 1'b0;
      armed   <= 1'b0;
      cool    <= 1'b0;
    end else begin
      state   <= state_nxt;
      enable  <= enable_nxt;
      int_out <= (state_nxt == S_ASSERT);
      armed   <= 1'b1;
      cool    <= (state == S_SERVICE) && eoi;
      if (state == S_IDLE && state_nxt == S_ASSERT) src_id <= sel_id;
    end
  end
endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed scenarios plus randomized traffic against
// a rule-level reference model.

module tb_int_arbiter;
  localparam int NSRC = 8;
  localparam int IDW  = 3;

  logic            clk, rst;
  logic [NSRC-1:0] req, mask_data, pending;
  logic            mask_wr, ack, eoi, int_out, busy;
  logic [IDW-1:0]  src_id;
  logic [12:0]     o, e;
  int              errors, checks;

  int_arbiter #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .mask_wr(mask_wr), .mask_data(mask_data),
    .ack(ack), .eoi(eoi), .int_out(int_out), .src_id(src_id),
    .pending(pending), .busy(busy)
  );

  assign o = {int_out, busy, src_id, pending};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 presenting, 2 being serviced.
  typedef struct packed {
    logic [1:0] mode;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] en;
    logic [7:0] last;
    logic       seen;
    logic       quiet;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, logic [7:0] r, logic mw,
                                         logic [7:0] md, logic a, logic x);
    mstate_t    n = s;
    logic [7:0] new_en = mw ? md : s.en;
    logic [7:0] rose   = s.seen ? (r & ~s.last) : 8'h00;
    logic [7:0] cand   = s.pend & s.en;
    if (s.mode == 2'd0 && !s.quiet && cand != 0) begin
      for (int i = 7; i >= 0; i--) if (cand[i]) n.id = 3'(i);
      n.mode = 2'd1;
    end else if (s.mode == 2'd1 && a) begin
      n.pend[s.id] = 1'b0;
      n.mode = 2'd2;
    end else if (s.mode == 2'd1 && !new_en[s.id]) begin
      n.mode = 2'd0;
    end else if (s.mode == 2'd2 && x) begin
      n.mode = 2'd0;
    end
    n.quiet = (s.mode == 2'd2) && x;
    n.pend  = n.pend | rose;
    n.en    = new_en;
    n.last  = r;
    n.seen  = 1'b1;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, req, mask_wr, mask_data, ack, eoi);
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; mask_wr = 1'b0; mask_data = '0; ack = 1'b0; eoi = 1'b0;
    #1;
    e = '0; checks++;
    if (o !== e) begin errors++; $display("FAIL reset_async: got %h want %h", o, e); end
    step; step;
    rst = 1'b0;
    step;
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_release: got %h want %h", o, e); end
  endtask

  task automatic test_basic;
    mask_wr = 1'b1; mask_data = 8'hFF; step; mask_wr = 1'b0;
    req = 8'h20; step;
    e = {1'b0, 1'b0, 3'd0, 8'h20}; checks++;
    if (o !== e) begin errors++; $display("FAIL basic_pend: got %h want %h", o, e); end
    req = 8'h00; step;
    e = {1'b1, 1'b1, 3'd5, 8'h20}; checks++;
    if (o !== e) begin errors++; $display("FAIL basic_assert: got %h want %h", o, e); end
    ack = 1'b1; step; ack = 1'b0;
    e = {1'b0, 1'b1, 3'd5, 8'h00}; checks++;
    if (o !== e) begin errors++; $display("FAIL basic_ack: got %h want %h", o, e); end
    eoi = 1'b1; step; eoi = 1'b0;
    e = {1'b0, 1'b0, 3'd5, 8'h00}; checks++;
    if (o !== e) begin errors++; $display("FAIL basic_eoi: got %h want %h", o, e); end
    step; step;
  endtask

  task automatic test_priority;
    int lows;
    req = 8'h44; step; req = 8'h00; step;
    e = {1'b1, 1'b1, 3'd2, 8'h44}; checks++;
    if (o !== e) begin errors++; $display("FAIL prio_first: got %h want %h", o, e); end
    ack = 1'b1; step; ack = 1'b0;
    eoi = 1'b1; step; eoi = 1'b0;
    lows = (int_out == 1'b0) ? 1 : 0;
    for (int n = 0; n < 10 && int_out == 1'b0; n++) begin
      step;
      if (int_out == 1'b0) lows++;
    end
    checks++;
    if (lows < 2) begin errors++; $display("FAIL prio_gap: low cycles %0d want >=2", lows); end
    e = {1'b1, 1'b1, 3'd6, 8'h40}; checks++;
    if (o !== e) begin errors++; $display("FAIL prio_second: got %h want %h", o, e); end
    ack = 1'b1; step; ack = 1'b0;
    eoi = 1'b1; step; eoi = 1'b0;
    step; step;
  endtask

  task automatic test_mask;
    mask_wr = 1'b1; mask_data = 8'h00; step; mask_wr = 1'b0;
    req = 8'h08; step; req = 8'h00; step; step;
    e = {1'b0, 1'b0, 3'd6, 8'h08}; checks++;
    if (o !== e) begin errors++; $display("FAIL mask_blocked: got %h want %h", o, e); end
    mask_wr = 1'b1; mask_data = 8'h08; step; mask_wr = 1'b0; step;
    e = {1'b1, 1'b1, 3'd3, 8'h08}; checks++;
    if (o !== e) begin errors++; $display("FAIL mask_enable: got %h want %h", o, e); end
    ack = 1'b1; step; ack = 1'b0;
    eoi = 1'b1; step; eoi = 1'b0;
    mask_wr = 1'b1; mask_data = 8'hFF; step; mask_wr = 1'b0;
    step;
  endtask

  task automatic test_withdraw;
    req = 8'h10; step; req = 8'h00; step;
    e = {1'b1, 1'b1, 3'd4, 8'h10}; checks++;
    if (o !== e) begin errors++; $display("FAIL wd_assert: got %h want %h", o, e); end
    mask_wr = 1'b1; mask_data = 8'h00; step; mask_wr = 1'b0;
    e = {1'b0, 1'b0, 3'd4, 8'h10}; checks++;
    if (o !== e) begin errors++; $display("FAIL wd_withdraw: got %h want %h", o, e); end
    step; step;
    checks++;
    if (o !== e) begin errors++; $display("FAIL wd_hold: got %h want %h", o, e); end
    mask_wr = 1'b1; mask_data = 8'hFF; step; mask_wr = 1'b0; step;
    ack = 1'b1; step; ack = 1'b0;
    eoi = 1'b1; step; eoi = 1'b0;
    step; step;
  endtask

  task automatic test_ack_set;
    req = 8'h02; step; req = 8'h00; step;
    e = {1'b1, 1'b1, 3'd1, 8'h02}; checks++;
    if (o !== e) begin errors++; $display("FAIL as_assert: got %h want %h", o, e); end
    ack = 1'b1; req = 8'h02; step; ack = 1'b0; req = 8'h00;
    e = {1'b0, 1'b1, 3'd1, 8'h02}; checks++;
    if (o !== e) begin errors++; $display("FAIL as_setwins: got %h want %h", o, e); end
    eoi = 1'b1; step; eoi = 1'b0; step; step;
    e = {1'b1, 1'b1, 3'd1, 8'h02}; checks++;
    if (o !== e) begin errors++; $display("FAIL as_repeat: got %h want %h", o, e); end
    ack = 1'b1; step; ack = 1'b0;
    eoi = 1'b1; step; eoi = 1'b0;
    step; step;
  endtask

  task automatic test_reset_mid;
    req = 8'h01; step; step;
    ack = 1'b1; step; ack = 1'b0;
    e = {1'b0, 1'b1, 3'd0, 8'h00}; checks++;
    if (o !== e) begin errors++; $display("FAIL rm_service: got %h want %h", o, e); end
    #1 rst = 1'b1;
    #1;
    e = '0; checks++;
    if (o !== e) begin errors++; $display("FAIL rm_async: got %h want %h", o, e); end
    step; step;
    rst = 1'b0;
    mask_wr = 1'b1; mask_data = 8'hFF; step; mask_wr = 1'b0;
    step; step; step;
    checks++;
    if (o !== e) begin errors++; $display("FAIL rm_noedge: got %h want %h", o, e); end
    req = 8'h00; step; req = 8'h01; step; step;
    e = {1'b1, 1'b1, 3'd0, 8'h01}; checks++;
    if (o !== e) begin errors++; $display("FAIL rm_reedge: got %h want %h", o, e); end
    ack = 1'b1; step; ack = 1'b0;
    eoi = 1'b1; step; eoi = 1'b0;
    req = 8'h00; step; step;
  endtask

  task automatic test_random;
    for (int n = 0; n < 600; n++) begin
      req       = 8'($urandom & $urandom);
      mask_wr   = ($urandom_range(0, 9) == 0);
      mask_data = 8'($urandom | $urandom);
      ack       = int_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      eoi       = (busy && !int_out) ? ($urandom_range(0, 2) == 0)
                                     : ($urandom_range(0, 15) == 0);
      step;
      e = {m.mode == 2'd1, m.mode != 2'd0, m.id, m.pend}; checks++;
      if (o !== e) begin errors++; $display("FAIL rand_%0d: got %h want %h", n, o, e); end
    end
    req = '0; mask_wr = 1'b0; ack = 1'b0; eoi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_basic;
    test_priority;
    test_mask;
    test_withdraw;
    test_ack_set;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
